// File: rtl/adc_frame_scheduler.sv
// Periodic ADC frame scheduler: a timebase launches start_req/start_ack handshakes,
// with finite-burst support and sticky/saturating overrun tracking of dropped ticks.
module adc_frame_scheduler #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned FRM_W = 16
) (
  input  logic             input_clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [FRM_W-1:0] burst_len,
  output logic             start_req,
  input  logic             start_ack,
  input  logic             done,
  input  logic             clear_overrun,
  output logic             tick,
  output logic             frame_toggle,
  output logic [FRM_W-1:0] frame_count,
  output logic             overrun,
  output logic [FRM_W-1:0] overrun_count,
  output logic             burst_done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] per_eff_c;
  logic [FRM_W-1:0] rem_q, rem_d;
  logic [FRM_W-1:0] fcnt_q, fcnt_d;
  logic [FRM_W-1:0] ovr_cnt_q, ovr_cnt_d;
  logic             fin_q, fin_d;
  logic             req_q, req_d;
  logic             tick_q, tick_d;
  logic             tog_q, tog_d;
  logic             ovr_q, ovr_d;
  logic             bdone_q, bdone_d;
  logic             wrap_c;
  logic             last_c;
  logic             ovr_evt_c;

  // A zero period would wrap every cycle; clamp to the 2-cycle minimum interval.
  assign per_eff_c = (period == '0) ? CNT_W'(1) : period;
  assign wrap_c    = (state_q != S_IDLE) && (cnt_q == per_q);
  assign last_c    = fin_q && (rem_q == FRM_W'(1));

  // A tick is lost while a request is pending or a frame is in flight, unless it
  // coincides with done, in which case it arms the next request instead.
  assign ovr_evt_c = wrap_c && ((state_q == S_REQ) || ((state_q == S_RUN) && !done));

  always_comb begin
    state_d   = state_q;
    cnt_d     = ((state_q == S_IDLE) || wrap_c) ? '0 : cnt_q + CNT_W'(1);
    per_d     = wrap_c ? per_eff_c : per_q;
    rem_d     = rem_q;
    fin_d     = fin_q;
    tog_d     = tog_q;
    fcnt_d    = fcnt_q;
    bdone_d   = 1'b0;
    ovr_d     = ovr_evt_c ? 1'b1 : (clear_overrun ? 1'b0 : ovr_q);
    ovr_cnt_d = (ovr_evt_c && (ovr_cnt_q != '1)) ? ovr_cnt_q + FRM_W'(1) : ovr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
          per_d   = per_eff_c;
          rem_d   = burst_len;
          fin_d   = (burst_len != '0);
          fcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (wrap_c) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (start_ack) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (done) begin
          tog_d  = ~tog_q;
          fcnt_d = fcnt_q + FRM_W'(1);
          if (fin_q) begin
            rem_d = rem_q - FRM_W'(1);
          end
          if (last_c) begin
            state_d = S_IDLE;
            bdone_d = 1'b1;
          end else if (!enable) begin
            state_d = S_IDLE;
          end else if (wrap_c) begin
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      cnt_d = '0;
    end
    tick_d = wrap_c;
    req_d  = (state_d == S_REQ);
  end

  always_ff @(posedge input_clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      per_q     <= CNT_W'(1);
      rem_q     <= '0;
      fin_q     <= 1'b0;
      req_q     <= 1'b0;
      tick_q    <= 1'b0;
      tog_q     <= 1'b0;
      fcnt_q    <= '0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      bdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      rem_q     <= rem_d;
      fin_q     <= fin_d;
      req_q     <= req_d;
      tick_q    <= tick_d;
      tog_q     <= tog_d;
      fcnt_q    <= fcnt_d;
      ovr_q     <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
      bdone_q   <= bdone_d;
    end
  end

  assign start_req     = req_q;
  assign tick          = tick_q;
  assign frame_toggle  = tog_q;
  assign frame_count   = fcnt_q;
  assign overrun       = ovr_q;
  assign overrun_count = ovr_cnt_q;
  assign burst_done    = bdone_q;
  assign state         = state_q;

endmodule
